// File: rtl/usb_pkg.sv
// Shared USB protocol definitions: packet framing constants, PID codes,
// field bit positions, transaction kind codes and the device FSM states.
package usb_pkg;

  // Packet framing
  localparam int PKT_W = 99;
  localparam logic [7:0] SYNC = 8'h01;

  // PID values
  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;

  // Field bit positions inside a packet
  localparam int SYNC_HI = 98;
  localparam int SYNC_LO = 91;
  localparam int PID_HI  = 90;
  localparam int PID_LO  = 83;
  localparam int ADDR_HI = 82;
  localparam int ADDR_LO = 76;
  localparam int ENDP_HI = 75;
  localparam int ENDP_LO = 72;
  localparam int PAY_HI  = 82;
  localparam int PAY_LO  = 19;
  localparam int PAD_HI  = 18;

  // Transaction kind codes decoded from a token PID
  localparam logic [1:0] TRANS_NONE = 2'd0;
  localparam logic [1:0] TRANS_OUT  = 2'd1;
  localparam logic [1:0] TRANS_IN   = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DATA = 3'd1,
    ST_SEND_DATA = 3'd2,
    ST_WAIT_HS   = 3'd3,
    ST_SEND_HS   = 3'd4
  } dev_state_t;

  // Classify a PID as an OUT token, an IN token, or anything else.
  function automatic logic [1:0] token_kind(input logic [7:0] pid);
    logic [1:0] kind;
    case (pid)
      PID_OUT: kind = TRANS_OUT;
      PID_IN:  kind = TRANS_IN;
      default: kind = TRANS_NONE;
    endcase
    return kind;
  endfunction

  // Build a handshake packet: SYNC, PID and all lower bits zero.
  function automatic logic [PKT_W-1:0] make_hs_pkt(input logic [7:0] pid);
    return {SYNC, pid, 83'd0};
  endfunction

  // Build a DATA0 packet carrying a 64-bit payload.
  function automatic logic [PKT_W-1:0] make_data_pkt(input logic [63:0] payload);
    return {SYNC, PID_DATA0, payload, 19'd0};
  endfunction

endpackage

// File: rtl/dev_protocol_if.sv
// Bus bundle between the device protocol responder (master side) and its
// surroundings: packet decoder/encoder and the endpoint buffers.
interface dev_protocol_if;
  import usb_pkg::*;

  logic [PKT_W-1:0] pkt_from_dec;
  logic             pkt_from_dec_avail;
  logic             pkt_from_dec_corrupt;
  logic [PKT_W-1:0] pkt_to_enc;
  logic             pkt_to_enc_avail;
  logic             pkt_sent;
  logic [3:0]       ep_endp;
  logic             ep_wr_ready;
  logic             ep_wr_en;
  logic [63:0]      ep_wr_data;
  logic             ep_rd_valid;
  logic [63:0]      ep_rd_data;
  logic             ep_rd_ack;
  logic             xact_done;
  logic             xact_ok;

  // Responder view
  modport master (
    input  pkt_from_dec, pkt_from_dec_avail, pkt_from_dec_corrupt, pkt_sent,
           ep_wr_ready, ep_rd_valid, ep_rd_data,
    output pkt_to_enc, pkt_to_enc_avail, ep_endp, ep_wr_en, ep_wr_data,
           ep_rd_ack, xact_done, xact_ok
  );

  // Environment view (codec and endpoint buffers)
  modport slave (
    output pkt_from_dec, pkt_from_dec_avail, pkt_from_dec_corrupt, pkt_sent,
           ep_wr_ready, ep_rd_valid, ep_rd_data,
    input  pkt_to_enc, pkt_to_enc_avail, ep_endp, ep_wr_en, ep_wr_data,
           ep_rd_ack, xact_done, xact_ok
  );

endinterface

// File: rtl/dev_timeout.sv
// Wait-state timeout counter: cleared while not waiting, counts each
// waiting cycle and flags when the count reaches TIMEOUT_LEN.
module dev_timeout #(
  parameter logic [7:0] TIMEOUT_LEN = 8'd255
) (
  input  logic clk,
  input  logic rst_b,
  input  logic i_en,
  input  logic i_clr,
  output logic o_fire
);

  logic [7:0] r_count;

  // Count waiting cycles, holding at the limit until cleared.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_count <= 8'd0;
    end else if (i_clr) begin
      r_count <= 8'd0;
    end else if (i_en && (r_count != TIMEOUT_LEN)) begin
      r_count <= r_count + 8'd1;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_fire = i_en && !i_clr && (r_count == TIMEOUT_LEN);

endmodule

// File: rtl/dev_protocol.sv
// Device-side USB transaction responder: answers OUT tokens with ACK/NAK
// after the DATA0 stage and IN tokens with DATA0/NAK, then tracks the
// host handshake. All outputs are registered.
module dev_protocol
  import usb_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'd5,
  parameter logic [7:0] TIMEOUT_LEN = 8'd255
) (
  input logic            clk,
  input logic            rst_b,
  dev_protocol_if.master bus
);

  dev_state_t       r_state;
  logic [PKT_W-1:0] r_pkt_to_enc;
  logic             r_pkt_to_enc_avail;
  logic [3:0]       r_ep_endp;
  logic             r_ep_wr_en;
  logic [63:0]      r_ep_wr_data;
  logic             r_ep_rd_ack;
  logic             r_xact_done;
  logic             r_xact_ok;
  logic             r_hs_ack;   // handshake being sent is an ACK

  logic [7:0]  w_pid;
  logic [6:0]  w_addr;
  logic [3:0]  w_endp;
  logic [63:0] w_payload;
  logic [1:0]  w_kind;
  logic        w_pkt_good;
  logic        w_wait;
  logic        w_tmo_clr;
  logic        w_tmo_fire;
  logic        w_unused_bits;

  assign w_pid      = bus.pkt_from_dec[PID_HI:PID_LO];
  assign w_addr     = bus.pkt_from_dec[ADDR_HI:ADDR_LO];
  assign w_endp     = bus.pkt_from_dec[ENDP_HI:ENDP_LO];
  assign w_payload  = bus.pkt_from_dec[PAY_HI:PAY_LO];
  assign w_kind     = token_kind(w_pid);
  assign w_pkt_good = bus.pkt_from_dec_avail && !bus.pkt_from_dec_corrupt;
  assign w_wait     = (r_state == ST_WAIT_DATA) || (r_state == ST_WAIT_HS);
  assign w_tmo_clr  = !w_wait;

  // SYNC and the data padding are not interpreted by the responder.
  assign w_unused_bits = ^{bus.pkt_from_dec[SYNC_HI:SYNC_LO],
                           bus.pkt_from_dec[PAD_HI:0]};

  dev_timeout #(
    .TIMEOUT_LEN(TIMEOUT_LEN)
  ) u_timeout (
    .clk    (clk),
    .rst_b  (rst_b),
    .i_en   (w_wait),
    .i_clr  (w_tmo_clr),
    .o_fire (w_tmo_fire)
  );

  // Transaction FSM with registered packet, strobes and completion status.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_state            <= ST_IDLE;
      r_pkt_to_enc       <= '0;
      r_pkt_to_enc_avail <= 1'b0;
      r_ep_endp          <= 4'd0;
      r_ep_wr_en         <= 1'b0;
      r_ep_wr_data       <= 64'd0;
      r_ep_rd_ack        <= 1'b0;
      r_xact_done        <= 1'b0;
      r_xact_ok          <= 1'b0;
      r_hs_ack           <= 1'b0;
    end else begin
      // Strobes last exactly one cycle.
      r_ep_wr_en  <= 1'b0;
      r_ep_rd_ack <= 1'b0;
      r_xact_done <= 1'b0;
      r_xact_ok   <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_pkt_good && (w_addr == DEV_ADDR)) begin
            case (w_kind)
              TRANS_OUT: begin
                r_ep_endp <= w_endp;
                r_state   <= ST_WAIT_DATA;
              end
              TRANS_IN: begin
                r_ep_endp          <= w_endp;
                r_pkt_to_enc_avail <= 1'b1;
                if (bus.ep_rd_valid) begin
                  r_pkt_to_enc <= make_data_pkt(bus.ep_rd_data);
                  r_state      <= ST_SEND_DATA;
                end else begin
                  r_pkt_to_enc <= make_hs_pkt(PID_NAK);
                  r_hs_ack     <= 1'b0;
                  r_state      <= ST_SEND_HS;
                end
              end
              default: begin
                r_state <= ST_IDLE;
              end
            endcase
          end
        end

        ST_WAIT_DATA: begin
          // An arriving packet takes precedence over a same-cycle timeout.
          if (bus.pkt_from_dec_avail) begin
            if (bus.pkt_from_dec_corrupt || (w_pid != PID_DATA0)) begin
              r_xact_done <= 1'b1;
              r_state     <= ST_IDLE;
            end else if (bus.ep_wr_ready) begin
              r_ep_wr_en         <= 1'b1;
              r_ep_wr_data       <= w_payload;
              r_pkt_to_enc       <= make_hs_pkt(PID_ACK);
              r_pkt_to_enc_avail <= 1'b1;
              r_hs_ack           <= 1'b1;
              r_state            <= ST_SEND_HS;
            end else begin
              r_pkt_to_enc       <= make_hs_pkt(PID_NAK);
              r_pkt_to_enc_avail <= 1'b1;
              r_hs_ack           <= 1'b0;
              r_state            <= ST_SEND_HS;
            end
          end else if (w_tmo_fire) begin
            r_xact_done <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        ST_SEND_DATA: begin
          if (bus.pkt_sent) begin
            r_pkt_to_enc_avail <= 1'b0;
            r_state            <= ST_WAIT_HS;
          end
        end

        ST_WAIT_HS: begin
          if (bus.pkt_from_dec_avail) begin
            r_xact_done <= 1'b1;
            r_state     <= ST_IDLE;
            if (w_pkt_good && (w_pid == PID_ACK)) begin
              r_ep_rd_ack <= 1'b1;
              r_xact_ok   <= 1'b1;
            end
          end else if (w_tmo_fire) begin
            r_xact_done <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        ST_SEND_HS: begin
          if (bus.pkt_sent) begin
            r_pkt_to_enc_avail <= 1'b0;
            r_xact_done        <= 1'b1;
            r_xact_ok          <= r_hs_ack;
            r_state            <= ST_IDLE;
          end
        end

        default: begin
          r_pkt_to_enc_avail <= 1'b0;
          r_state            <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.pkt_to_enc       = r_pkt_to_enc;
  assign bus.pkt_to_enc_avail = r_pkt_to_enc_avail;
  assign bus.ep_endp          = r_ep_endp;
  assign bus.ep_wr_en         = r_ep_wr_en;
  assign bus.ep_wr_data       = r_ep_wr_data;
  assign bus.ep_rd_ack        = r_ep_rd_ack;
  assign bus.xact_done        = r_xact_done;
  assign bus.xact_ok          = r_xact_ok;

endmodule
